// File: rtl/chess_pkg.sv
// Shared encodings and default sizing for the chess clock front-end.
// FSM state codes are exported on STATE, so they must stay fixed.
package chess_pkg;

    localparam int N_DEF      = 16;
    localparam int DIV_DEF    = 1000;
    localparam int DB_CYC_DEF = 16;
    localparam int ST_W       = 3;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ARMED = 3'd1,
        ST_RUN1  = 3'd2,
        ST_RUN2  = 3'd3,
        ST_PAUSE = 3'd4,
        ST_FLAG  = 3'd5
    } state_t;

    function automatic logic is_run(state_t s);
        return (s == ST_RUN1) || (s == ST_RUN2);
    endfunction

endpackage

// File: rtl/chess_turn_ctrl_if.sv
// Control bus between the turn controller (master) and the two-counter clock core (slave).
// LOAD/IN reload both counters; CT_1/CT_2 decrement one; Z_FLG reports a counter at zero.
interface chess_turn_ctrl_if #(
    parameter int N = chess_pkg::N_DEF
);
    logic         LOAD;
    logic [N-1:0] IN;
    logic         CT_1;
    logic         CT_2;
    logic         Z_FLG;

    modport master (output LOAD, IN, CT_1, CT_2, input Z_FLG);
    modport slave  (input LOAD, IN, CT_1, CT_2, output Z_FLG);
endinterface

// File: rtl/chess_turn_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability-count debounce, rising-edge press pulse.
// Latency: raw edge to PRESS is 2 + DB_CYC + 1 cycles.
// No backpressure: PRESS is a single-cycle pulse and is lost if not consumed.
module btn_debounce #(
    parameter int DB_CYC = 16
) (
    input  logic CLK,
    input  logic A_CLR,
    input  logic RAW,
    output logic LEVEL,
    output logic PRESS
);
    localparam int CW = $clog2(DB_CYC);

    logic          sync_1;
    logic          sync_2;
    logic          level_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge CLK or posedge A_CLR) begin
        if (A_CLR) begin
            sync_1  <= 1'b0;
            sync_2  <= 1'b0;
            LEVEL   <= 1'b0;
            level_d <= 1'b0;
            PRESS   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_1  <= RAW;
            sync_2  <= sync_1;
            level_d <= LEVEL;
            PRESS   <= LEVEL & ~level_d;
            // Any return to the accepted level restarts the stability window.
            if (sync_2 == LEVEL) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                LEVEL <= sync_2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/chess_turn_ctrl.sv
// Chess clock front-end: debounced buttons drive the game FSM, prescaler and decrement strobes.
// Latency: button press to STATE/LOAD change is one cycle after the debounced press pulse.
// No backpressure: the core accepts LOAD/CT_x every cycle; Z_FLG is sampled every cycle.
module chess_turn_ctrl
    import chess_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int DIV    = DIV_DEF,
    parameter int DB_CYC = DB_CYC_DEF
) (
    input  logic               CLK,
    input  logic               A_CLR,
    input  logic               BTN_1,
    input  logic               BTN_2,
    input  logic               BTN_PAUSE,
    input  logic               BTN_NEW,
    input  logic [N-1:0]       TIME_SEL,
    output logic [ST_W-1:0]    STATE,
    chess_turn_ctrl_if.master  core
);
    localparam int PW = $clog2(DIV);

    logic [3:0]    lvl;
    logic          prs_1, prs_2, prs_p, prs_new;
    state_t        state_q, state_d;
    logic          resume_q, resume_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          wrap;
    logic [N-1:0]  in_q;
    logic          load_q, ct1_q, ct2_q;
    logic          unused_lvl;

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_1     (.CLK(CLK), .A_CLR(A_CLR), .RAW(BTN_1),     .LEVEL(lvl[0]), .PRESS(prs_1));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_2     (.CLK(CLK), .A_CLR(A_CLR), .RAW(BTN_2),     .LEVEL(lvl[1]), .PRESS(prs_2));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_pause (.CLK(CLK), .A_CLR(A_CLR), .RAW(BTN_PAUSE), .LEVEL(lvl[2]), .PRESS(prs_p));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_new   (.CLK(CLK), .A_CLR(A_CLR), .RAW(BTN_NEW),   .LEVEL(lvl[3]), .PRESS(prs_new));

    assign unused_lvl = &{1'b0, lvl};

    assign wrap = (pre_q == PW'(DIV - 1));

    always_comb begin
        state_d  = state_q;
        resume_d = resume_q;
        if (prs_new) begin
            state_d = ST_ARMED;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (prs_2 && !prs_1)      state_d = ST_RUN1;
                    else if (prs_1 && !prs_2) state_d = ST_RUN2;
                end
                ST_RUN1: begin
                    if (core.Z_FLG)  state_d = ST_FLAG;
                    else if (prs_1)  state_d = ST_RUN2;
                    else if (prs_p) begin
                        state_d  = ST_PAUSE;
                        resume_d = 1'b0;
                    end
                end
                ST_RUN2: begin
                    if (core.Z_FLG)  state_d = ST_FLAG;
                    else if (prs_2)  state_d = ST_RUN1;
                    else if (prs_p) begin
                        state_d  = ST_PAUSE;
                        resume_d = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (prs_p) state_d = resume_q ? ST_RUN2 : ST_RUN1;
                end
                default: ;
            endcase
        end
    end

    // Prescaler phase survives turn switches and pauses; only NEW restarts it.
    always_comb begin
        pre_d = pre_q;
        if (prs_new)              pre_d = '0;
        else if (is_run(state_q)) pre_d = wrap ? '0 : pre_q + PW'(1);
    end

    always_ff @(posedge CLK or posedge A_CLR) begin
        if (A_CLR) begin
            state_q  <= ST_IDLE;
            resume_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            resume_q <= resume_d;
        end
    end

    // Strobes use the current state, so a turn-ending edge still credits the ending player.
    always_ff @(posedge CLK or posedge A_CLR) begin
        if (A_CLR) begin
            pre_q  <= '0;
            in_q   <= '0;
            load_q <= 1'b0;
            ct1_q  <= 1'b0;
            ct2_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            load_q <= prs_new;
            if (prs_new) in_q <= TIME_SEL;
            ct1_q  <= (state_q == ST_RUN1) && wrap;
            ct2_q  <= (state_q == ST_RUN2) && wrap;
        end
    end

    assign STATE     = state_q;
    assign core.LOAD = load_q;
    assign core.IN   = in_q;
    assign core.CT_1 = ct1_q;
    assign core.CT_2 = ct2_q;

endmodule
